// File: rtl/io_read_return.sv
`default_nettype none
// ============================================================================
// Module  : io_read_return
// Brief   : MEM-stage IO load sequencer: memory/register read return, stall,
//           sticky button status and display-select registers.
// Revision: 1.0 - initial release
// ============================================================================
module io_read_return #(
    parameter int DATA_W = 32,
    parameter int PIX_W  = 8,
    parameter int NBTN   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wdata,
    input  logic              mem_enb,
    input  logic              show_enb,
    input  logic              show_original_enb,
    input  logic              original_enb,
    input  logic              process_enb,
    input  logic              btn_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [PIX_W-1:0]  orig_rdata,
    input  logic [PIX_W-1:0]  proc_rdata,
    input  logic [NBTN-1:0]   btn_raw,
    output logic              stall,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              show_reg,
    output logic              show_original_reg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] C_RGN_MEM  = 2'd0;
    localparam logic [1:0] C_RGN_ORIG = 2'd1;
    localparam logic [1:0] C_RGN_PROC = 2'd2;

    state_t              r_state;
    state_t              w_next_state;
    logic [1:0]          r_region;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_show;
    logic                r_show_orig;
    logic [NBTN-1:0]     r_btn_sync1;
    logic [NBTN-1:0]     r_btn_sync2;
    logic [NBTN-1:0]     r_btn_sync3;
    logic [NBTN-1:0]     r_btn_sticky;

    logic                w_mem_sel;
    logic [1:0]          w_region_code;
    logic                w_rd_accept;
    logic                w_wr_accept;
    logic                w_btn_sel;
    logic [NBTN-1:0]     w_btn_edge;
    logic [NBTN-1:0]     w_btn_clr;
    logic [DATA_W-1:0]   w_reg_rdata;
    logic [DATA_W-1:0]   w_mem_rdata;
    logic                w_unused_wdata;

    assign w_unused_wdata = ^wdata[DATA_W-1:1];

    assign w_mem_sel     = mem_enb | original_enb | process_enb;
    assign w_region_code = original_enb ? C_RGN_ORIG :
                           process_enb  ? C_RGN_PROC : C_RGN_MEM;
    assign w_rd_accept   = (r_state == S_IDLE) && rd_req;
    assign w_wr_accept   = (r_state == S_IDLE) && wr_req && !rd_req;

    // Register-region priority: show, show_original, buttons, else unmapped.
    assign w_btn_sel = btn_rd && !show_enb && !show_original_enb;

    always_comb begin
        w_reg_rdata = '0;
        if (show_enb)
            w_reg_rdata = {{(DATA_W-1){1'b0}}, r_show};
        else if (show_original_enb)
            w_reg_rdata = {{(DATA_W-1){1'b0}}, r_show_orig};
        else if (btn_rd)
            w_reg_rdata = {{(DATA_W-NBTN){1'b0}}, r_btn_sticky};
    end

    always_comb begin
        w_mem_rdata = mem_rdata;
        case (r_region)
            C_RGN_ORIG: w_mem_rdata = {{(DATA_W-PIX_W){1'b0}}, orig_rdata};
            C_RGN_PROC: w_mem_rdata = {{(DATA_W-PIX_W){1'b0}}, proc_rdata};
            default:    w_mem_rdata = mem_rdata;
        endcase
    end

    assign w_btn_edge = r_btn_sync2 & ~r_btn_sync3;
    assign w_btn_clr  = {NBTN{w_rd_accept && !w_mem_sel && w_btn_sel}};

    // Next state and handshake outputs; both forced low while in reset.
    always_comb begin
        w_next_state = r_state;
        stall        = 1'b0;
        rd_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall = rd_req;
                if (rd_req)
                    w_next_state = w_mem_sel ? S_WAIT : S_RESP;
            end
            S_WAIT: begin
                stall        = 1'b1;
                w_next_state = S_RESP;
            end
            S_RESP: begin
                rd_valid     = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
        if (!rst) begin
            stall    = 1'b0;
            rd_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_region     <= C_RGN_MEM;
            r_rdata      <= '0;
            r_show       <= 1'b0;
            r_show_orig  <= 1'b0;
            r_btn_sync1  <= '0;
            r_btn_sync2  <= '0;
            r_btn_sync3  <= '0;
            r_btn_sticky <= '0;
        end else begin
            r_state      <= w_next_state;
            r_btn_sync1  <= btn_raw;
            r_btn_sync2  <= r_btn_sync1;
            r_btn_sync3  <= r_btn_sync2;
            // New edges override a simultaneous clear-on-read.
            r_btn_sticky <= (r_btn_sticky & ~w_btn_clr) | w_btn_edge;

            if (w_rd_accept) begin
                if (w_mem_sel)
                    r_region <= w_region_code;
                else
                    r_rdata <= w_reg_rdata;
            end
            if (r_state == S_WAIT)
                r_rdata <= w_mem_rdata;

            if (w_wr_accept && show_enb)
                r_show <= wdata[0];
            if (w_wr_accept && show_original_enb)
                r_show_orig <= wdata[0];
        end
    end

    assign rdata             = r_rdata;
    assign show_reg          = r_show;
    assign show_original_reg = r_show_orig;

endmodule
`default_nettype wire
